// File: rtl/req_enc_pkg.sv
// Shared constants, FSM state type and address/bit-index mapping for req_encoder12to4.
// Address 1..12 maps onto req[11]..req[0]; address 0 means no grant.
package req_enc_pkg;

  localparam int unsigned N_REQ  = 12;
  localparam int unsigned ADDR_W = 4;
  localparam logic [ADDR_W-1:0] ADDR_NONE = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    BUSY
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr);
    return ADDR_W'(N_REQ - 32'(addr));
  endfunction

  function automatic logic [N_REQ-1:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
    logic [N_REQ-1:0] oh;
    oh = '0;
    if (addr != ADDR_NONE && 32'(addr) <= N_REQ) oh[addr_to_idx(addr)] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/req_encoder12to4_rr_priority_pick.sv
// Rotating priority encoder: first requesting address after last_addr, wrapping 12 -> 1.
module rr_priority_pick
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              hit,
  output logic [ADDR_W-1:0] winner_addr
);

  logic [ADDR_W-1:0] cand;

  always_comb begin
    hit         = 1'b0;
    winner_addr = ADDR_NONE;
    cand        = ADDR_NONE;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ADDR_W'((32'(last_addr) + k - 1) % N_REQ + 1);
      if (!hit && req[addr_to_idx(cand)]) begin
        hit         = 1'b1;
        winner_addr = cand;
      end
    end
  end

endmodule

// File: rtl/req_encoder12to4.sv
// Round-robin 12-to-4 request encoder with valid/ready grant offer and done release.
// Optional BUSY watchdog enabled by defining REQ_ENC_TIMEOUT_EN.
module req_encoder12to4
  import req_enc_pkg::*;
`ifdef REQ_ENC_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 255
)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [ADDR_W-1:0] grant_addr,
  output logic [N_REQ-1:0]  grant_onehot,
  output logic              grant_valid,
  input  logic              grant_ready,
  input  logic              done,
  output logic              timeout_err
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] last_addr, last_nx, addr_nx;
  logic              hit;
  logic [ADDR_W-1:0] winner_addr;
  logic              expire;

  rr_priority_pick u_pick (
    .req         (req),
    .last_addr   (last_addr),
    .hit         (hit),
    .winner_addr (winner_addr)
  );

`ifdef REQ_ENC_TIMEOUT_EN
  logic [7:0] busy_cnt;
  logic       err_nx;

  // busy_cnt counts completed BUSY cycles; expire marks the TIMEOUT-th one.
  assign expire = (state == BUSY) && (busy_cnt == 8'(TIMEOUT - 1));
  assign err_nx = expire && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      busy_cnt    <= (state == BUSY) ? busy_cnt + 8'd1 : '0;
      timeout_err <= err_nx;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    addr_nx  = grant_addr;
    last_nx  = last_addr;
    unique case (state)
      IDLE: begin
        if (hit) begin
          addr_nx  = winner_addr;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        // Acceptance takes precedence over the owner withdrawing its request.
        if (grant_ready) begin
          state_nx = BUSY;
        end else if (!req[addr_to_idx(grant_addr)]) begin
          addr_nx  = ADDR_NONE;
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (done || expire) begin
          last_nx  = grant_addr;
          addr_nx  = ADDR_NONE;
          state_nx = IDLE;
        end
      end
      default: begin
        addr_nx  = ADDR_NONE;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_addr <= ADDR_NONE;
      last_addr  <= ADDR_W'(N_REQ);
    end else begin
      state      <= state_nx;
      grant_addr <= addr_nx;
      last_addr  <= last_nx;
    end
  end

  assign grant_valid  = (state == OFFER);
  assign grant_onehot = addr_to_onehot(grant_addr);

endmodule

// File: tb/tb_req_encoder12to4.sv
// Scoreboard bench for req_encoder12to4: stimulus pushes expected grants, a negedge monitor
// pops and compares on every new offer. Directed cases plus randomized transactions.
module tb_req_encoder12to4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] req;
  logic [3:0]  grant_addr;
  logic [11:0] grant_onehot;
  logic        grant_valid;
  logic        grant_ready;
  logic        done;
  logic        timeout_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_q[$];
  int unsigned m_last = 12;
  logic        prev_valid = 1'b0;
  int unsigned mon_e;

`ifdef REQ_ENC_TIMEOUT_EN
  req_encoder12to4 #(.TIMEOUT(4)) dut (
`else
  req_encoder12to4 dut (
`endif
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .grant_addr   (grant_addr),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference: smallest requested address above last, else smallest requested overall.
  function automatic int unsigned model_pick(input logic [11:0] r, input int unsigned last);
    int unsigned lowest = 0;
    int unsigned above  = 0;
    logic [11:0] v;
    v = r;
    for (int unsigned a = 1; a <= 12; a++) begin
      if (v[4'(12 - a)]) begin
        if (lowest == 0) lowest = a;
        if (above == 0 && a > last) above = a;
      end
    end
    return (above != 0) ? above : lowest;
  endfunction

  function automatic logic [11:0] model_onehot(input int unsigned a);
    logic [11:0] m;
    m = '0;
    if (a >= 1 && a <= 12) m[4'(12 - a)] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && grant_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_offer: got addr %0d, expected no offer (t=%0t)", grant_addr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("offer_addr", grant_addr, mon_e);
        check("offer_onehot", grant_onehot, model_onehot(mon_e));
      end
    end
    prev_valid = rst_n && grant_valid;
  end

  task automatic grant_txn(input logic [11:0] r, input int unsigned rd, input int unsigned dd);
    int unsigned e;
    e = model_pick(r, m_last);
    exp_q.push_back(e);
    req = r;
    @(negedge clk);
    check("latency_valid", grant_valid, 1);
    for (int unsigned i = 0; i < rd; i++) begin
      req = r & (12'($urandom) | model_onehot(e));
      @(negedge clk);
      check("offer_hold_valid", grant_valid, 1);
      check("offer_hold_addr", grant_addr, e);
    end
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    check("busy_valid", grant_valid, 0);
    for (int unsigned i = 0; i < dd; i++) begin
      req = 12'($urandom);
      @(negedge clk);
      check("busy_hold_addr", grant_addr, e);
    end
    req  = '0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("release_addr", grant_addr, 0);
    check("release_onehot", grant_onehot, 0);
    check("no_timeout_err", timeout_err, 0);
    m_last = e;
  endtask

  task automatic cancel_txn(input logic [11:0] r, input int unsigned rd);
    int unsigned e;
    e = model_pick(r, m_last);
    exp_q.push_back(e);
    req = r;
    @(negedge clk);
    check("cancel_offer_valid", grant_valid, 1);
    repeat (rd) @(negedge clk);
    req = '0;
    @(negedge clk);
    check("cancel_valid", grant_valid, 0);
    check("cancel_addr", grant_addr, 0);
    check("cancel_onehot", grant_onehot, 0);
  endtask

  task automatic ready_drop_txn(input logic [11:0] r);
    int unsigned e;
    e = model_pick(r, m_last);
    exp_q.push_back(e);
    req = r;
    @(negedge clk);
    grant_ready = 1'b1;
    req = '0;
    @(negedge clk);
    grant_ready = 1'b0;
    check("ready_drop_valid", grant_valid, 0);
    check("ready_drop_busy_addr", grant_addr, e);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("ready_drop_release", grant_addr, 0);
    m_last = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] r;
    int unsigned e, pulses, first, errs, chg;
    rst_n = 1'b0; req = '0; grant_ready = 1'b0; done = 1'b0;
    #1;
    check("reset_addr", grant_addr, 0);
    check("reset_onehot", grant_onehot, 0);
    check("reset_valid", grant_valid, 0);
    check("reset_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round robin with every line requesting: 1..12 then 1.
    for (int unsigned i = 0; i < 13; i++) grant_txn(12'hFFF, 0, 0);

    // Wrap priority: last=11, req 12'h801 -> 12, then 1.
    grant_txn(12'h002, 0, 0);
    grant_txn(12'h801, 0, 0);
    grant_txn(12'h801, 0, 0);

    // Cancel leaves last_addr untouched; next FFF grant follows previous owner.
    cancel_txn(12'h010, 1);
    grant_txn(12'hFFF, 0, 0);

    ready_drop_txn(12'h0F0);

    // done in IDLE is ignored.
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("idle_done_valid", grant_valid, 0);
    check("idle_done_addr", grant_addr, 0);
    grant_txn(12'hFFF, 1, 1);

    for (int unsigned n = 0; n < 40; n++) begin
      r = 12'($urandom_range(1, 4095));
      if ($urandom_range(0, 4) == 0) cancel_txn(r, $urandom_range(0, 2));
      else grant_txn(r, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Asynchronous reset while BUSY with grant 5.
    exp_q.push_back(model_pick(12'h080, m_last));
    req = 12'h080;
    @(negedge clk);
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    req = '0;
    check("pre_reset_addr", grant_addr, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_addr", grant_addr, 0);
    check("async_reset_onehot", grant_onehot, 0);
    check("async_reset_valid", grant_valid, 0);
    check("async_reset_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 12;
    grant_txn(12'h800, 0, 0);

`ifdef REQ_ENC_TIMEOUT_EN
    e = model_pick(12'h100, m_last);
    exp_q.push_back(e);
    req = 12'h100;
    @(negedge clk);
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    req = '0;
    pulses = 0; first = 0;
    for (int unsigned k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 3) check("to_still_busy", grant_addr, e);
      if (k == 4) check("to_idle_addr", grant_addr, 0);
    end
    check("to_pulse_count", pulses, 1);
    check("to_pulse_cycle", first, 4);
    m_last = e;

    // done coinciding with the expiry cycle suppresses the error pulse.
    e = model_pick(12'h00C, m_last);
    exp_q.push_back(e);
    req = 12'h00C;
    @(negedge clk);
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("to_done_wins_addr", grant_addr, 0);
    check("to_done_wins_err", timeout_err, 0);
    @(negedge clk);
    check("to_done_wins_err2", timeout_err, 0);
    m_last = e;
    grant_txn(12'hFFF, 0, 0);
`else
    e = model_pick(12'h100, m_last);
    exp_q.push_back(e);
    req = 12'h100;
    @(negedge clk);
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    req = '0;
    errs = 0; chg = 0;
    for (int unsigned k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (timeout_err) errs++;
      if (grant_addr != 4'(e) || grant_valid) chg++;
    end
    check("hold_no_err", errs, 0);
    check("hold_addr_stable", chg, 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("hold_release", grant_addr, 0);
    m_last = e;
    grant_txn(12'hFFF, 0, 0);
`endif

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
